// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int arb_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority finder: first set valid bit at or after ptr_i, wrapping modulo N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = arb_id_width(N)
) (
    input  logic [N-1:0]   valid_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           any_o,
    output logic [IDW-1:0] idx_o
);

    // Scan from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (valid_i[j]) begin
                any_o = 1'b1;
                idx_o = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// rotating after BURST_LEN beats or when the granted producer drops valid.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int N_REQ     = 3,
    parameter int BURST_LEN = 2,
    localparam int IDW      = arb_id_width(N_REQ),
    localparam int CW       = arb_id_width(BURST_LEN)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_req_o,
    output logic [WIDTH-1:0]       fifo_wr_data_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic [IDW-1:0]         grant_id_o
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

    logic           in_burst;
    logic           gnt_valid;
    logic           beat;
    logic           burst_release;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW-1:0] pick_ptr;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    assign in_burst      = (state_q == BURST);
    assign gnt_valid     = req_valid_i[gnt_id_q];
    assign beat          = in_burst & gnt_valid & ~fifo_full_i;
    assign burst_release = in_burst &
                           ((beat & (beat_cnt_q == CW'(BURST_LEN - 1))) | ~gnt_valid);
    assign nxt_ptr       = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

    // On release the new winner is searched from the producer after the old one.
    assign pick_ptr = in_burst ? nxt_ptr : rr_ptr_q;

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (pick_ptr),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BURST;
                    gnt_id_d   = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (burst_release) begin
                    rr_ptr_d   = nxt_ptr;
                    beat_cnt_d = '0;
                    if (pick_any) begin
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_id_d = '0;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Everything is derived from reset-cleared registers, so outputs drop with rst_i.
    always_comb begin
        grant_o        = '0;
        grant_id_o     = '0;
        req_ready_o    = '0;
        fifo_wr_req_o  = beat;
        fifo_wr_data_o = '0;
        if (in_burst) begin
            grant_o[gnt_id_q]     = 1'b1;
            grant_id_o            = gnt_id_q;
            req_ready_o[gnt_id_q] = beat;
            fifo_wr_data_o        = req_data_i[int'(gnt_id_q) * WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter driving a 4-entry FIFO model; expected write data is
// queued when a scenario starts and popped as each write appears.
module tb_fifo_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  req_valid_i;
    logic [11:0] req_data_i;
    logic [2:0]  req_ready_o;
    logic        fifo_full_i;
    logic        fifo_wr_req_o;
    logic [3:0]  fifo_wr_data_o;
    logic [2:0]  grant_o;
    logic [1:0]  grant_id_o;
    logic        rd_en;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  fq[$];

    fifo_wr_arbiter #(
        .WIDTH     (4),
        .N_REQ     (3),
        .BURST_LEN (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_req_o  (fifo_wr_req_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .grant_id_o     (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // 4-entry FIFO: full reflects the count after each edge, writes ignored while full.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fq.delete();
            fifo_full_i <= 1'b0;
        end else begin
            if (rd_en && fq.size() > 0) begin
                void'(fq.pop_front());
            end
            if (fifo_wr_req_o && !fifo_full_i) begin
                fq.push_back(fifo_wr_data_o);
            end
            fifo_full_i <= (fq.size() >= 4);
        end
    end

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && fifo_wr_req_o === 1'b1) begin
            $display("t=%0t write data=%h grant=%b", $time, fifo_wr_data_o, grant_o);
            chk("wr_not_full", 32'(fifo_full_i), 32'd0);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("wr_data", 32'(fifo_wr_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        req_data_i = {d2, d1, d0};
    endtask

    task automatic do_reset();
        req_valid_i = 3'b000;
        rd_en       = 1'b0;
        rst_i       = 1'b0;
        #2;
        rst_i       = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic [2:0] rdy,
                           input logic wr);
        chk({tag, "_grant"}, 32'(grant_o), 32'(g));
        chk({tag, "_ready"}, 32'(req_ready_o), 32'(rdy));
        chk({tag, "_wr"}, 32'(fifo_wr_req_o), 32'(wr));
    endtask

    logic [2:0] fair_grant[8] = '{3'b001, 3'b001, 3'b010, 3'b010,
                                  3'b100, 3'b100, 3'b001, 3'b001};
    logic [3:0] fair_data[8]  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h1, 4'h1};

    initial begin
        rst_i       = 1'b0;
        rd_en       = 1'b0;
        req_valid_i = 3'b111;
        set_data(4'h1, 4'h2, 4'h3);

        // Reset held with all producers valid
        #1;
        chk_out("rst_t0", 3'b000, 3'b000, 1'b0);
        tick();
        tick();
        chk_out("rst_hold", 3'b000, 3'b000, 1'b0);
        chk("rst_id", 32'(grant_id_o), 32'd0);
        chk("rst_data", 32'(fifo_wr_data_o), 32'd0);
        rst_i = 1'b1;
        tick();
        chk("rst_first_grant", 32'(grant_o), 32'b001);
        req_valid_i = 3'b000;
        tick();
        do_reset();

        // Single producer, re-granted with no bubble
        set_data(4'h0, 4'h5, 4'h0);
        req_valid_i = 3'b010;
        repeat (4) exp_q.push_back(4'h5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("single", 3'b010, 3'b010, 1'b1);
            chk("single_id", 32'(grant_id_o), 32'd1);
        end
        tick();
        chk("single_full", 32'(fifo_full_i), 32'd1);
        chk_out("single_stall", 3'b010, 3'b000, 1'b0);
        req_valid_i = 3'b000;
        chk("single_fifo_cnt", 32'(fq.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < fq.size()) chk("single_fifo_data", 32'(fq[k]), 32'h5);
        end
        tick();
        chk("single_idle", 32'(grant_o), 32'b000);
        req_valid_i = 3'b111;
        tick();
        chk("idle_ptr_grant", 32'(grant_o), 32'b100);
        req_valid_i = 3'b000;
        tick();
        do_reset();

        // Fairness with all producers valid and the FIFO drained every cycle
        set_data(4'h1, 4'h2, 4'h3);
        rd_en       = 1'b1;
        req_valid_i = 3'b111;
        for (int i = 0; i < 8; i++) exp_q.push_back(fair_data[i]);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fair_grant", 32'(grant_o), 32'(fair_grant[i]));
            chk("fair_wr", 32'(fifo_wr_req_o), 32'd1);
        end
        tick();
        req_valid_i = 3'b000;
        tick();
        do_reset();

        // Full stall during producer 0's second beat
        set_data(4'h7, 4'h0, 4'hA);
        req_valid_i = 3'b100;
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h7);
        exp_q.push_back(4'h7);
        tick();
        chk("stall_g2", 32'(grant_o), 32'b100);
        tick();
        tick();
        tick();
        req_valid_i = 3'b001;
        #1;
        chk_out("stall_handover", 3'b100, 3'b000, 1'b0);
        tick();
        chk_out("stall_first", 3'b001, 3'b001, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_full", 32'(fifo_full_i), 32'd1);
            chk_out("stall_hold", 3'b001, 3'b000, 1'b0);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("stall_unfull", 32'(fifo_full_i), 32'd0);
        chk_out("stall_resume", 3'b001, 3'b001, 1'b1);
        tick();
        req_valid_i = 3'b000;
        tick();
        do_reset();

        // Granted producer drops valid after one beat
        set_data(4'h3, 4'h0, 4'h9);
        req_valid_i = 3'b101;
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h9);
        tick();
        chk_out("drop_g0", 3'b001, 3'b001, 1'b1);
        tick();
        req_valid_i = 3'b100;
        #1;
        chk_out("drop_release", 3'b001, 3'b000, 1'b0);
        tick();
        chk_out("drop_g2", 3'b100, 3'b100, 1'b1);
        chk("drop_id", 32'(grant_id_o), 32'd2);
        tick();
        req_valid_i = 3'b000;
        tick();
        do_reset();

        // Asynchronous reset in the middle of producer 2's burst
        set_data(4'h0, 4'h0, 4'hB);
        req_valid_i = 3'b100;
        exp_q.push_back(4'hB);
        tick();
        chk_out("arst_g2", 3'b100, 3'b100, 1'b1);
        tick();
        #1;
        rst_i       = 1'b0;
        req_valid_i = 3'b111;
        #1;
        chk_out("arst_drop", 3'b000, 3'b000, 1'b0);
        chk("arst_id", 32'(grant_id_o), 32'd0);
        chk("arst_data", 32'(fifo_wr_data_o), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("arst_regrant", 32'(grant_o), 32'b001);
        req_valid_i = 3'b000;
        tick();
        tick();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the `fifo` block between N_REQ independent producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN beats, forwards that producer's data to the FIFO write port, and stalls on FIFO full. It sits directly in front of a `fifo` instance: its outputs connect to wr_req_i/wr_data_i, and fifo full_o feeds back into it.

Parameters:
WIDTH, 4, data word width; must match the fifo WIDTH.
N_REQ, 3, number of producers, 1..16.
BURST_LEN, 2, maximum beats per grant before rotation, >=1.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, asynchronous, active-low (0 = reset).
req_valid_i  in  N_REQ  per-producer valid.
req_data_i  in  N_REQ*WIDTH  packed producer data; producer k occupies bits [k*WIDTH +: WIDTH].
req_ready_o  out  N_REQ  per-producer ready; one-hot or zero.
fifo_full_i  in  1  from fifo full_o.
fifo_wr_req_o  out  1  to fifo wr_req_i.
fifo_wr_data_o  out  WIDTH  to fifo wr_data_i.
grant_o  out  N_REQ  registered one-hot current grant; zero when idle.
grant_id_o  out  $clog2(N_REQ) min 1  index of the current grant; 0 when idle.

Behaviour:
- States: IDLE, BURST. Registers: state, gnt_id, rr_ptr, beat_cnt.
- Reset (rst_i=0, takes effect immediately, not on an edge): state=IDLE, rr_ptr=0, beat_cnt=0, gnt_id=0. All outputs go to 0 at once: grant_o, grant_id_o, req_ready_o, fifo_wr_req_o, fifo_wr_data_o.
- Pick function: the first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- IDLE:
  - If any valid: go to BURST with gnt_id=pick, beat_cnt=0.
  - Otherwise stay in IDLE.
  - No writes occur in IDLE.
- BURST, with g = gnt_id:
  - fifo_wr_data_o = producer g's data slice (combinational mux).
  - beat = req_valid_i[g] & ~fifo_full_i.
  - fifo_wr_req_o = beat; req_ready_o[g] = beat; all other ready bits are 0.
  - On a beat, beat_cnt increments.
- Release condition, evaluated in BURST:
  - (a) a beat occurs with beat_cnt == BURST_LEN-1, or
  - (b) req_valid_i[g] = 0.
- On release:
  - rr_ptr <= (g+1) mod N_REQ.
  - Re-arbitrate in the same cycle using pointer (g+1) mod N_REQ and the current valids.
  - If any valid: stay in BURST with the new gnt_id and beat_cnt=0. There is no idle bubble; g may win again if it is the only valid producer.
  - Otherwise: go to IDLE.
- fifo_full_i=1 in BURST: no beat, beat_cnt holds, the grant holds indefinitely. A full FIFO never causes a release.
- Latency: a valid asserted in IDLE is granted at the next edge. The first write takes place in the cycle grant_o is visible, provided the FIFO is not full.
- Producer rule: data must stay stable while valid=1 and ready=0. The arbiter does not check this.
- fifo_wr_data_o = 0 in IDLE.
- N_REQ=1: always grants producer 0 and re-grants every BURST_LEN beats with no bubble.
- The arbiter never asserts fifo_wr_req_o while fifo_full_i=1.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum arb_state_t {IDLE, BURST};
  - a function for the id width (clog2, with a minimum of 1).
- One sub-module, rr_pick: combinational rotate-priority finder. Inputs: valid vector and pointer. Outputs: any flag and index.
- The top level holds the FSM, counters and data mux.

Test Plan:
(All scenarios use WIDTH=4, N_REQ=3, BURST_LEN=2, driven into a real fifo with DEPTH_BIT=2.)
1. Reset: hold rst_i=0 with all valids high → every output is 0. Release → grant_o=3'b001 at the first edge.
2. Single producer: only producer 1 valid, data 4'h5, held for 4 beats → grant_o=3'b010 one cycle later. fifo_wr_req_o is high on 4 consecutive cycles with no bubble at the 2-beat re-grant, and the fifo holds 5,5,5,5.
3. Fairness: all three valid, data 4'h1/4'h2/4'h3, fifo drained each cycle → write order 1,1,2,2,3,3,1,1… with no idle cycles.
4. Full stall: fill the fifo (4 entries) with fifo_full_i=1 during producer 0's second beat, then read one entry → fifo_wr_req_o=0 and req_ready_o=0 while full. The grant stays 3'b001, and the pending beat completes in the cycle after full clears.
5. Valid drop: producer 0 drops valid after 1 beat while producer 2 is valid → release. Grant moves to 3'b100 (producer 1 is not valid), rr_ptr=1, and producer 2 writes immediately.
6. Async reset mid-burst: assert rst_i=0 between edges during producer 2's grant → grant_o and fifo_wr_req_o drop to 0 without waiting for an edge. After release, producer 0 gets the first grant.
